gray_counter: RTL

- Parametrised registered Gray-code counter; successor to the 4-bit combinational binary-to-Gray converter.
- Holds a binary count and its Gray encoding, both registered and updated on the same edge.
- Supports:
  - up/down counting,
  - synchronous load of a binary or Gray value, with Gray-to-binary conversion on load,
  - wrap or saturate at the limits.
- Used as a pointer source for clock-domain-crossing FIFOs and as a Gray position encoder.

---
 rtl/gray_counter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/gray_counter.sv
// -----------------------------------------------------------------------------
// gray_counter
// -----------------------------------------------------------------------------
// Parametrised registered Gray-code counter. It holds a binary count and the
// matching Gray code. Both are registered and updated on the same clock edge.
// The Gray register is loaded from the next-state binary value, not decoded
// after the flop. Downstream logic, such as a CDC synchroniser, therefore sees
// a glitch-free value. On each count step exactly one Gray bit changes,
// including the step that wraps.
//
// Features:
//   - up/down counting, one step per enabled cycle
//   - synchronous load of a binary or Gray value (Gray loads are converted
//     to binary before being stored)
//   - wrap-around (WRAP = 1) or saturation (WRAP = 0) at the limits
//   - registered at_max / at_min flags and a one-cycle wrap pulse
//
// Priority at each rising edge: load > en > hold.
//
// Parameters:
//   WIDTH  count width in bits (>= 2)
//   WRAP   1 = wrap around at the limits, 0 = saturate at the limits
//
// Ports:
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   en            in   count enable
//   up            in   direction: 1 = increment, 0 = decrement
//   load          in   synchronous load strobe, overrides en
//   load_val      in   [WIDTH] value to load
//   load_is_gray  in   1 = load_val is Gray-coded, 0 = binary
//   q_bin         out  [WIDTH] registered binary count
//   q_gray        out  [WIDTH] registered Gray count (q_bin ^ (q_bin >> 1))
//   wrap          out  one-cycle pulse in the cycle the wrapped value appears
//   at_max        out  registered, q_bin == 2^WIDTH-1
//   at_min        out  registered, q_bin == 0
// -----------------------------------------------------------------------------
module gray_counter #(
  parameter int unsigned WIDTH = 4,
  parameter bit          WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             load_is_gray,
  output logic [WIDTH-1:0] q_bin,
  output logic [WIDTH-1:0] q_gray,
  output logic             wrap,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;
  localparam logic [WIDTH-1:0] MIN_VAL = '0;
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // Code conversions
  // ---------------------------------------------------------------------------
  function automatic logic [WIDTH-1:0] bin_to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray-to-binary conversion runs as a prefix XOR from the MSB down:
  // b[MSB] = g[MSB], then b[i] = b[i+1] ^ g[i].
  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b            = '0;
    b[WIDTH-1]   = g[WIDTH-1];
    for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] bin_q,    bin_d;
  logic [WIDTH-1:0] gray_q,   gray_d;
  logic             wrap_q,   wrap_d;
  logic             at_max_q, at_max_d;
  logic             at_min_q, at_min_d;

  // Limit detection on the current count. It steers the wrap/saturate choice.
  logic cur_is_max;
  logic cur_is_min;

  assign cur_is_max = (bin_q == MAX_VAL);
  assign cur_is_min = (bin_q == MIN_VAL);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first. That keeps any path
  // through the if/else tree from leaving a value unassigned, which would
  // infer a latch.
  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;

    if (load) begin
      // Load wins over en. wrap stays low even when the loaded value is a limit.
      bin_d = load_is_gray ? gray_to_bin(load_val) : load_val;
    end else if (en) begin
      if (up) begin
        if (cur_is_max) begin
          if (WRAP) begin
            bin_d  = MIN_VAL;
            wrap_d = 1'b1;
          end
          // Saturating build: hold at the top.
        end else begin
          bin_d = bin_q + ONE;
        end
      end else begin
        if (cur_is_min) begin
          if (WRAP) begin
            bin_d  = MAX_VAL;
            wrap_d = 1'b1;
          end
          // Saturating build: hold at the bottom.
        end else begin
          bin_d = bin_q - ONE;
        end
      end
    end

    // Derive Gray and the flags from the next binary value, so every output
    // is registered and updates on the same edge as q_bin.
    gray_d   = bin_to_gray(bin_d);
    at_max_d = (bin_d == MAX_VAL);
    at_min_d = (bin_d == MIN_VAL);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments here keep every flop sampling its
  // pre-edge value. Blocking assignments would make the result depend on
  // statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: all state is reset, including the flags. at_min resets high
      // because a count of 0 is at the bottom limit.
      bin_q    <= MIN_VAL;
      gray_q   <= MIN_VAL;
      wrap_q   <= 1'b0;
      at_max_q <= 1'b0;
      at_min_q <= 1'b1;
    end else begin
      bin_q    <= bin_d;
      gray_q   <= gray_d;
      wrap_q   <= wrap_d;
      at_max_q <= at_max_d;
      at_min_q <= at_min_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: driven straight from flops, with no input-to-output combinational path.
  // ---------------------------------------------------------------------------
  assign q_bin  = bin_q;
  assign q_gray = gray_q;
  assign wrap   = wrap_q;
  assign at_max = at_max_q;
  assign at_min = at_min_q;

endmodule
